// File: rtl/mem_arb_pkg.sv
// Shared types and parameter limits for the unified memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {OWN_IF, OWN_D} owner_t;
    typedef enum logic {ST_IDLE, ST_BUSY} arb_state_t;

    localparam int STREAK_MIN = 1;
    localparam int STREAK_LIMIT = 15;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;
    // Wide enough to count up to LAT_MAX.
    localparam int LAT_W = 3;

endpackage

// File: rtl/arb_streak.sv
// Saturating count of consecutive data grants made while fetch is waiting;
// force_if tells the arbiter that fetch must win the next contention.
module arb_streak
    import mem_arb_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic d_grant,
    input  logic if_grant,
    output logic force_if
);

    localparam int SW = $clog2(MAX_STREAK + 1);

    logic [SW-1:0] streak;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (!if_req || if_grant) begin
            streak <= '0;
        end else if (d_grant && (streak != SW'(MAX_STREAK))) begin
            streak <= streak + SW'(1);
        end
    end

    assign force_if = (streak == SW'(MAX_STREAK));

endmodule

// File: rtl/mem_port_arbiter.sv
// Grants the single memory port to fetch or data, tracks the one outstanding
// access through the fixed read latency and routes the response to its owner.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY    = 1,
    parameter int MEM_AW     = 10,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX ||
        MAX_STREAK < STREAK_MIN || MAX_STREAK > STREAK_LIMIT) begin : g_bad_param
        $error("mem_port_arbiter: LATENCY or MAX_STREAK out of range");
    end

    arb_state_t       state, state_next;
    owner_t           own, own_next;
    logic             store, store_next;
    logic [LAT_W-1:0] lat_cnt, lat_next;

    logic resp;
    logic arb_ok;
    logic force_if;
    logic pick_d;
    logic pick_if;
    logic grant_d;
    logic grant_if;
    logic addr_unused;

    // Only the word-address field reaches the memory; the rest wraps away.
    assign addr_unused = ^{if_addr[1:0], if_addr[31:MEM_AW+2],
                           d_addr[1:0], d_addr[31:MEM_AW+2]};

    assign resp   = (state == ST_BUSY) && (lat_cnt == LAT_W'(LATENCY));
    assign arb_ok = (state == ST_IDLE) || resp;

    // Data wins contention unless fetch has waited out a full streak.
    assign pick_d   = d_req && !(if_req && force_if);
    assign pick_if  = if_req && !pick_d;
    assign grant_d  = rst_n && arb_ok && pick_d;
    assign grant_if = rst_n && arb_ok && pick_if;

    arb_streak #(
        .MAX_STREAK(MAX_STREAK)
    ) u_streak (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .d_grant  (grant_d),
        .if_grant (grant_if),
        .force_if (force_if)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            own     <= OWN_IF;
            store   <= 1'b0;
            lat_cnt <= '0;
        end else begin
            state   <= state_next;
            own     <= own_next;
            store   <= store_next;
            lat_cnt <= lat_next;
        end
    end

    always_comb begin
        state_next = state;
        own_next   = own;
        store_next = store;
        lat_next   = lat_cnt;
        if (grant_d || grant_if) begin
            state_next = ST_BUSY;
            own_next   = grant_d ? OWN_D : OWN_IF;
            store_next = grant_d && d_we;
            lat_next   = LAT_W'(1);
        end else if (resp) begin
            state_next = ST_IDLE;
            lat_next   = '0;
        end else if (state == ST_BUSY) begin
            lat_next = lat_cnt + LAT_W'(1);
        end
    end

    always_comb begin
        if_gnt    = grant_if;
        d_gnt     = grant_d;
        mem_en    = grant_d || grant_if;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        if (grant_d) begin
            mem_we    = d_we;
            mem_addr  = d_addr[MEM_AW+1:2];
            mem_wdata = d_wdata;
        end else if (grant_if) begin
            mem_addr  = if_addr[MEM_AW+1:2];
        end
        // A reset cycle abandons the outstanding access, so its response is masked.
        if (rst_n && resp) begin
            if (own == OWN_IF) begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end else begin
                d_rvalid = 1'b1;
                d_rdata  = store ? 32'h0 : mem_rdata;
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between the IFU instruction-fetch path and the data load/store path of the multicycle MIPS core. Each cycle it grants at most one requester, drives the memory port, tracks the one outstanding access through a fixed read latency, and returns the response to its owner. Data accesses have priority, and a streak limit bounds how long fetch can be starved.

## Interface
Parameters:
- LATENCY, 1: memory read latency in cycles (legal 1..4).
- MEM_AW, 10: word-address width of the memory.
- MAX_STREAK, 4: number of consecutive data grants, while fetch waits, after which fetch wins.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset; sampled on posedge clk.
- if_req  in  1  fetch request; held with stable if_addr until if_gnt.
- if_addr  in  32  byte address of the fetch.
- if_gnt  out  1  one-cycle grant to fetch.
- if_rvalid  out  1  one-cycle fetch response valid.
- if_rdata  out  32  fetched instruction.
- d_req  in  1  data request; held with stable d_we, d_addr and d_wdata until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  one-cycle grant to data.
- d_rvalid  out  1  one-cycle data completion; for loads and stores.
- d_rdata  out  32  load data; 0 for stores.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  MEM_AW  word address, equal to req_addr[MEM_AW+1:2].
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid LATENCY cycles after mem_en.

## Operation
- States:
  - IDLE: no access outstanding.
  - BUSY: one access outstanding, with owner register own ∈ {IF, D} and latency counter lat_cnt.
- Arbitration is allowed in IDLE, and in BUSY during the response cycle (lat_cnt == LATENCY). This permits back-to-back accesses.
- Winner selection:
  - If only one requester is active, it wins.
  - If both are active, D wins, unless streak == MAX_STREAK, in which case IF wins.
- Grant cycle:
  - Assert the winner's gnt and mem_en.
  - Drive mem_we = d_we for a D grant, 0 for an IF grant.
  - Drive mem_addr and mem_wdata from the winner.
  - Load own, set lat_cnt = 1, go to BUSY.
- BUSY: increment lat_cnt each cycle.
- Response cycle (lat_cnt == LATENCY):
  - Pulse the owner's rvalid, with rdata = mem_rdata; store responses give d_rdata = 0.
  - The next state is BUSY if a new grant occurs in the same cycle, otherwise IDLE.
- Streak counter:
  - Increments on each D grant made while if_req = 1.
  - Clears on an IF grant, or on any cycle with if_req = 0.
  - Saturates at MAX_STREAK.
- Address alignment:
  - addr[1:0] is ignored; the access uses the word address.
  - Bits above MEM_AW+1 are ignored, so addresses wrap modulo the memory size.
- The non-owner's rvalid is never asserted. Both gnt outputs are never high together.

## Timing
- Grant at cycle T → owner's rvalid at cycle T+LATENCY.
- Peak throughput is one access per LATENCY cycles. With LATENCY = 1, one access every cycle.
- gnt, mem_en, mem_we, mem_addr and mem_wdata are combinational from the requests and state, within the same cycle.
- rvalid and rdata are combinational from state and mem_rdata.
- Reset values (rst_n = 0 at a posedge): state IDLE, streak 0, lat_cnt 0.
  - While rst_n is low, all gnt, rvalid and mem_en outputs are 0, and rdata and mem_* are 0.
- Reset mid-access: the outstanding access is abandoned and its rvalid is never produced. The first grant is possible in the first cycle after rst_n returns high.
- A request that deasserts before being granted is a protocol violation; behaviour is unspecified.

## Structure
- Package mem_arb_pkg holds:
  - typedef enum owner_t {OWN_IF, OWN_D}
  - typedef enum arb_state_t {ST_IDLE, ST_BUSY}
  - localparam for the MAX_STREAK range check.
- One sub-module, arb_streak: the saturating streak counter, producing force_if = (streak == MAX_STREAK).
- Everything else (winner selection, FSM, latency counter, response routing) lives in mem_port_arbiter.

## Test plan
- Fetch only, LATENCY=1:
  - Stimulus: if_req held, if_addr = 0, 4, 8 in turn; memory words 0xCA0F3355, 0x00330FFF, 0x20040008.
  - Response: if_gnt high every cycle; if_rvalid one cycle later with those three words in order.
- Contention, LATENCY=2, MAX_STREAK=4:
  - Stimulus: if_req and d_req held continuously.
  - Response: grant order D,D,D,D,IF,D,D,D,D,IF; grants spaced 2 cycles apart.
- Store then load, LATENCY=3:
  - Stimulus: store d_addr = 0x10, d_wdata = 0xDEADBEEF; then load d_addr = 0x10.
  - Response:
    - Store: d_rvalid at T+3 with d_rdata = 0.
    - Load: d_rdata = 0xDEADBEEF.
    - No if_rvalid during either access.
- Back-to-back overlap, LATENCY=2:
  - Stimulus: a new d_req arrives in the response cycle of an IF access.
  - Response: d_gnt and if_rvalid are high in the same cycle; d_rvalid follows 2 cycles later.
- Reset mid-access, LATENCY=3:
  - Stimulus: rst_n = 0 at T+1 after an IF grant.
  - Response: if_rvalid is never asserted; outputs are 0 during reset; a fresh request is granted in the first cycle after rst_n = 1.
- Address wrap, MEM_AW=10:
  - Stimulus: d_addr = 0x1004.
  - Response: mem_addr = 1.
